cache_refill_ctrl: RTL and testbench

- Miss-handling controller that sits directly downstream of the 2-way set-associative tag lookup path (64 sets, 23-bit tag, 64-bit block, 8 bytes per block).
- Consumes per-way hit indications from the tag comparators, drives the way-select for the tag/data muxes and stalls the pipeline.
- On a miss: fetches the 64-bit block from memory, writes tag, data and valid into the LRU victim way, updates per-set LRU state, then completes the access as a hit.

---
 rtl/cache_refill_ctrl_if.sv | 41 ++++
 rtl/cache_refill_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_if.sv
// Lookup, memory-read and array-write signals of the 2-way cache refill controller.
// master = pipeline/memory/array side, slave = the refill controller itself.
interface cache_refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 6,
    parameter int BLK_W  = 64
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              hit_way0;
    logic              hit_way1;
    logic              valid_way0;
    logic              valid_way1;
    logic              hit;
    logic              way_sel;
    logic              stall;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_valid;
    logic [BLK_W-1:0]  mem_rd_data;
    logic              wr_en_way0;
    logic              wr_en_way1;
    logic [IDX_W-1:0]  wr_index;
    logic [TAG_W-1:0]  wr_tag;
    logic [BLK_W-1:0]  wr_data;

    modport master (
        output cpu_req, cpu_addr, hit_way0, hit_way1, valid_way0, valid_way1,
        output mem_rd_valid, mem_rd_data,
        input  hit, way_sel, stall, mem_rd_req, mem_addr,
        input  wr_en_way0, wr_en_way1, wr_index, wr_tag, wr_data
    );

    modport slave (
        input  cpu_req, cpu_addr, hit_way0, hit_way1, valid_way0, valid_way1,
        input  mem_rd_valid, mem_rd_data,
        output hit, way_sel, stall, mem_rd_req, mem_addr,
        output wr_en_way0, wr_en_way1, wr_index, wr_tag, wr_data
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// 2-way cache miss controller: hits complete in 0 cycles; a miss stalls, refills the LRU victim and answers N+2 cycles later.
// Optional CACHE_PERF_CNT_EN adds wrapping 32-bit hit_count/miss_count outputs.
module cache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 6,
    parameter int BLK_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count,
`endif
    cache_refill_ctrl_if.slave bus
);
    localparam int OFF_W = ADDR_W - TAG_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;
    localparam int BA_W  = TAG_W + IDX_W;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, FILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic [BA_W-1:0]   blk_addr_q, blk_addr_d;
    logic              victim_q, victim_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wr_en_way0_q, wr_en_way0_d;
    logic              wr_en_way1_q, wr_en_way1_d;
    logic [IDX_W-1:0]  wr_index_q, wr_index_d;
    logic [TAG_W-1:0]  wr_tag_q, wr_tag_d;
    logic [BLK_W-1:0]  wr_data_q, wr_data_d;

    logic [BA_W-1:0]   req_blk;
    logic [IDX_W-1:0]  req_idx;
    logic              lookup_hit;
    logic              lookup_way;
    logic              fill_victim;
    logic              idle_hit;
    logic              miss_start;
    logic              fill_start;
    logic              hit_c;
    logic              way_sel_c;
    logic              stall_c;
    logic              unused_offset;

    assign req_blk       = bus.cpu_addr[ADDR_W-1:OFF_W];
    assign req_idx       = req_blk[IDX_W-1:0];
    assign unused_offset = ^bus.cpu_addr[OFF_W-1:0];
    assign lookup_hit    = bus.hit_way0 | bus.hit_way1;
    // Way0 wins when both comparators fire.
    assign lookup_way    = bus.hit_way1 & ~bus.hit_way0;
    // Fill an empty way first (way0 preferred); only evict by LRU when the set is full.
    assign fill_victim   = ~bus.valid_way0 ? 1'b0 :
                           (~bus.valid_way1 ? 1'b1 : lru_q[req_idx]);

    assign idle_hit   = (state_q == IDLE) & bus.cpu_req & lookup_hit;
    assign miss_start = (state_q == IDLE) & bus.cpu_req & ~lookup_hit;
    assign fill_start = (state_q == MEM_WAIT) & bus.mem_rd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (miss_start) state_d = MEM_WAIT;
            MEM_WAIT: if (bus.mem_rd_valid) state_d = FILL;
            FILL:     state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_c     = 1'b0;
        way_sel_c = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            IDLE: begin
                hit_c     = bus.cpu_req & lookup_hit;
                way_sel_c = lookup_way;
                stall_c   = bus.cpu_req & ~lookup_hit;
            end
            MEM_WAIT, FILL: stall_c = 1'b1;
            RESP: begin
                hit_c     = 1'b1;
                way_sel_c = victim_q;
            end
            default: ;
        endcase
    end

    assign bus.hit     = hit_c;
    assign bus.way_sel = way_sel_c;
    assign bus.stall   = stall_c;

    always_comb begin
        lru_d        = lru_q;
        blk_addr_d   = blk_addr_q;
        victim_d     = victim_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_addr_d   = mem_addr_q;
        wr_en_way0_d = 1'b0;
        wr_en_way1_d = 1'b0;
        wr_index_d   = wr_index_q;
        wr_tag_d     = wr_tag_q;
        wr_data_d    = wr_data_q;

        // LRU bit names the way to evict next, i.e. the one not just used.
        if (idle_hit) begin
            lru_d[req_idx] = ~lookup_way;
        end
        if (miss_start) begin
            blk_addr_d   = req_blk;
            victim_d     = fill_victim;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = {req_blk, {OFF_W{1'b0}}};
        end
        if (fill_start) begin
            mem_rd_req_d = 1'b0;
            wr_en_way0_d = ~victim_q;
            wr_en_way1_d = victim_q;
            wr_index_d   = blk_addr_q[IDX_W-1:0];
            wr_tag_d     = blk_addr_q[BA_W-1:IDX_W];
            wr_data_d    = bus.mem_rd_data;
        end
        if (state_q == FILL) begin
            lru_d[wr_index_q] = ~victim_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lru_q        <= '0;
            blk_addr_q   <= '0;
            victim_q     <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= '0;
            wr_en_way0_q <= 1'b0;
            wr_en_way1_q <= 1'b0;
            wr_index_q   <= '0;
            wr_tag_q     <= '0;
            wr_data_q    <= '0;
        end else begin
            lru_q        <= lru_d;
            blk_addr_q   <= blk_addr_d;
            victim_q     <= victim_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_addr_q   <= mem_addr_d;
            wr_en_way0_q <= wr_en_way0_d;
            wr_en_way1_q <= wr_en_way1_d;
            wr_index_q   <= wr_index_d;
            wr_tag_q     <= wr_tag_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.mem_rd_req = mem_rd_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.wr_en_way0 = wr_en_way0_q;
    assign bus.wr_en_way1 = wr_en_way1_q;
    assign bus.wr_index   = wr_index_q;
    assign bus.wr_tag     = wr_tag_q;
    assign bus.wr_data    = wr_data_q;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // The RESP completion of a refill is not counted as a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(idle_hit);
        miss_cnt_d = miss_cnt_q + 32'(miss_start);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    wr_en_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(wr_en_way0_q && wr_en_way1_q));
    wr_en_only_in_fill: assert property (@(posedge clk) disable iff (reset)
        (wr_en_way0_q || wr_en_way1_q) |-> (state_q == FILL));
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed plus randomized bench; the reference is a tag/valid array with per-way last-use timestamps.
module tb_cache_refill_ctrl;
    logic clk;
    logic reset;

    cache_refill_ctrl_if bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_refill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CACHE_PERF_CNT_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    logic [22:0] m_tag [64][2];
    bit          m_val [64][2];
    int          m_use [64][2];
    int          now_t = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (failure %0d)", name, obs, exp, n_fail);
        end
    endtask

    // Evict an empty way first (way0 before way1), otherwise the way used longest ago.
    function automatic bit victim_of(input int s);
        if (!m_val[s][0]) return 1'b0;
        if (!m_val[s][1]) return 1'b1;
        return m_use[s][1] < m_use[s][0];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_use[s][0] = 0;
            m_use[s][1] = 0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_perf();
`ifdef CACHE_PERF_CNT_EN
        check("hit_count", 64'(hit_count), 64'(exp_hits));
        check("miss_count", 64'(miss_count), 64'(exp_misses));
`endif
    endtask

    task automatic junk_inputs();
        bus.cpu_req     = 1'($urandom);
        bus.cpu_addr    = $urandom;
        bus.hit_way0    = 1'($urandom);
        bus.hit_way1    = 1'($urandom);
        bus.valid_way0  = 1'($urandom);
        bus.valid_way1  = 1'($urandom);
        bus.mem_rd_data = {$urandom, $urandom};
    endtask

    task automatic idle_cycle(input bit stray);
        @(negedge clk);
        junk_inputs();
        bus.cpu_req      = 1'b0;
        bus.mem_rd_valid = stray;
        #1;
        check("idle_hit", 64'(bus.hit), 64'(0));
        check("idle_stall", 64'(bus.stall), 64'(0));
        check("idle_mem_req", 64'(bus.mem_rd_req), 64'(0));
        check("idle_wr_en", 64'({bus.wr_en_way0, bus.wr_en_way1}), 64'(0));
    endtask

    task automatic access(input logic [31:0] addr, input int lat, input logic [63:0] data, input bit both);
        logic [22:0] tag;
        logic [31:0] blk;
        int          s;
        int          stalls;
        bit          h0, h1, way, v;
        tag = addr[31:9];
        s   = int'(addr[8:3]);
        blk = {addr[31:3], 3'b000};
        h0  = m_val[s][0] && (m_tag[s][0] == tag);
        h1  = m_val[s][1] && (m_tag[s][1] == tag);
        if (both) begin
            h0 = 1'b1;
            h1 = 1'b1;
        end
        @(negedge clk);
        bus.cpu_req      = 1'b1;
        bus.cpu_addr     = addr;
        bus.hit_way0     = h0;
        bus.hit_way1     = h1;
        bus.valid_way0   = both | m_val[s][0];
        bus.valid_way1   = both | m_val[s][1];
        bus.mem_rd_valid = 1'b0;
        #1;
        if (h0 || h1) begin
            way = h0 ? 1'b0 : 1'b1;
            check("hit", 64'(bus.hit), 64'(1));
            check("hit_way_sel", 64'(bus.way_sel), 64'(way));
            check("hit_stall", 64'(bus.stall), 64'(0));
            now_t++;
            m_use[s][way] = now_t;
            exp_hits++;
            idle_cycle(1'b0);
        end else begin
            v      = victim_of(s);
            stalls = 0;
            check("miss_hit", 64'(bus.hit), 64'(0));
            check("miss_stall", 64'(bus.stall), 64'(1));
            if (bus.stall) stalls++;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                junk_inputs();
                bus.mem_rd_valid = (c == lat);
                if (c == lat) bus.mem_rd_data = data;
                #1;
                check("wait_stall", 64'(bus.stall), 64'(1));
                if (bus.stall) stalls++;
                check("wait_hit", 64'(bus.hit), 64'(0));
                check("wait_mem_req", 64'(bus.mem_rd_req), 64'(1));
                check("wait_mem_addr", 64'(bus.mem_addr), 64'(blk));
                check("wait_wr_en", 64'({bus.wr_en_way0, bus.wr_en_way1}), 64'(0));
            end
            @(negedge clk);
            junk_inputs();
            bus.mem_rd_valid = 1'b0;
            #1;
            check("fill_stall", 64'(bus.stall), 64'(1));
            if (bus.stall) stalls++;
            check("fill_hit", 64'(bus.hit), 64'(0));
            check("fill_mem_req", 64'(bus.mem_rd_req), 64'(0));
            check("fill_wr_en_way0", 64'(bus.wr_en_way0), 64'(v == 1'b0));
            check("fill_wr_en_way1", 64'(bus.wr_en_way1), 64'(v == 1'b1));
            check("fill_wr_index", 64'(bus.wr_index), 64'(s));
            check("fill_wr_tag", 64'(bus.wr_tag), 64'(tag));
            check("fill_wr_data", bus.wr_data, data);
            @(negedge clk);
            junk_inputs();
            bus.mem_rd_valid = 1'($urandom);
            #1;
            check("resp_hit", 64'(bus.hit), 64'(1));
            check("resp_way_sel", 64'(bus.way_sel), 64'(v));
            check("resp_stall", 64'(bus.stall), 64'(0));
            check("resp_wr_en", 64'({bus.wr_en_way0, bus.wr_en_way1}), 64'(0));
            check("stall_cycles", 64'(stalls), 64'(lat + 2));
            m_tag[s][v] = tag;
            m_val[s][v] = 1'b1;
            now_t++;
            m_use[s][v] = now_t;
            exp_misses++;
        end
        check_perf();
    endtask

    initial begin
        int          s;
        logic [31:0] a;
        int          g;
        reset            = 1'b1;
        bus.cpu_req      = 1'b0;
        bus.cpu_addr     = '0;
        bus.hit_way0     = 1'b0;
        bus.hit_way1     = 1'b0;
        bus.valid_way0   = 1'b0;
        bus.valid_way1   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        for (int i = 0; i < 64; i++) begin
            m_tag[i][0] = '0;
            m_tag[i][1] = '0;
            m_val[i][0] = 1'b0;
            m_val[i][1] = 1'b0;
        end
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check("rst_hit", 64'(bus.hit), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_mem_req", 64'(bus.mem_rd_req), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_wr_en", 64'({bus.wr_en_way0, bus.wr_en_way1}), 64'(0));
        check("rst_wr_index", 64'(bus.wr_index), 64'(0));
        check("rst_wr_tag", 64'(bus.wr_tag), 64'(0));
        check("rst_wr_data", bus.wr_data, 64'(0));
        check_perf();
        @(negedge clk);
        reset = 1'b0;

        // Set 7: cold miss, fill second way, hit way1, hit way0, then a full-set eviction.
        access(32'h0000_1238, 3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        access(32'h0000_5238, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
        access(32'h0000_523C, 0, 64'h0, 1'b0);
        access(32'h0000_1238, 0, 64'h0, 1'b0);
        access(32'h0000_9238, 2, 64'hA5A5_5A5A_F0F0_0F0F, 1'b0);
        access(32'h0000_0038, 0, 64'h0, 1'b1);
        access(32'h0000_D23F, 4, 64'h1122_3344_5566_7788, 1'b0);

        // Reset while the refill is outstanding, then a late memory pulse.
        @(negedge clk);
        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = 32'h0000_20A0;
        bus.hit_way0   = 1'b0;
        bus.hit_way1   = 1'b0;
        bus.valid_way0 = 1'b0;
        bus.valid_way1 = 1'b0;
        #1;
        check("rmw_stall", 64'(bus.stall), 64'(1));
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        check("rmw_mem_req", 64'(bus.mem_rd_req), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset            = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        model_reset();
        check("rmw_req_dropped", 64'(bus.mem_rd_req), 64'(0));
        check("rmw_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rmw_stall_clr", 64'(bus.stall), 64'(0));
        check_perf();
        @(negedge clk);
        bus.mem_rd_valid = 1'b0;
        #1;
        check("rmw_no_write", 64'({bus.wr_en_way0, bus.wr_en_way1}), 64'(0));
        check("rmw_no_req", 64'(bus.mem_rd_req), 64'(0));
        @(negedge clk);
        #1;
        check("rmw_no_write2", 64'({bus.wr_en_way0, bus.wr_en_way1}), 64'(0));
        check("rmw_no_resp", 64'(bus.hit), 64'(0));

        // Three hits then two misses from a fresh reset.
        access(32'h0000_1238, 0, 64'h0, 1'b0);
        access(32'h0000_123B, 0, 64'h0, 1'b0);
        access(32'h0000_1239, 0, 64'h0, 1'b0);
        access(32'h0000_2AA8, 2, 64'hFEED_FACE_0000_0001, 1'b0);
        access(32'h0000_2CB0, 1, 64'hFEED_FACE_0000_0002, 1'b0);
        check_perf();

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0:       s = 0;
                1:       s = 7;
                default: s = 63;
            endcase
            a = {23'(32'h100 + $urandom_range(0, 3)), 6'(s), 3'($urandom)};
            access(a, int'($urandom_range(1, 5)), {$urandom, $urandom}, $urandom_range(0, 11) == 0);
            g = int'($urandom_range(0, 2));
            repeat (g) idle_cycle(1'($urandom));
        end
        idle_cycle(1'b0);
        check_perf();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
